// File: rtl/reu_pkg.sv
// rtl/reu_pkg.sv - REU transfer-type encodings, sequencer state encoding and strobe bundle
package reu_pkg;

  // Transfer type as presented by the command register
  typedef enum logic [1:0] {
    XT_STASH  = 2'b00,  // C64 -> REU
    XT_FETCH  = 2'b01,  // REU -> C64
    XT_SWAP   = 2'b10,  // exchange, two cycles per byte
    XT_VERIFY = 2'b11   // compare only
  } xfer_type_e;

  // Sequencer states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARM    = 3'd1;
  localparam logic [2:0] ST_WAITBA = 3'd2;
  localparam logic [2:0] ST_XFER   = 3'd3;
  localparam logic [2:0] ST_SWAPWR = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // Per-cycle bus strobes decoded from state, BA and transfer type
  typedef struct packed {
    logic next_ca;
    logic next_reua;
    logic ram_we;
    logic c_wr;
  } strobe_t;

endpackage

// File: rtl/reu_xfer_seq_if.sv
// rtl/reu_xfer_seq_if.sv - register-file and C64/REU bus signals of the transfer sequencer
interface reu_xfer_seq_if;
  // From the register file / CPU decode
  logic       ExecuteIn;
  logic       FF00DecodeIn;
  logic [1:0] XferTypeIn;
  logic       Length1;
  logic       FF00Wr;
  // Bus inputs
  logic       BA;
  logic [7:0] CDIn;
  logic [7:0] RDIn;
  // Bus outputs
  logic       DMAReq;
  logic       CRnW;
  logic       RAMWE;
  logic [7:0] CDOut;
  logic [7:0] RDOut;
  // Strobes back to the register file
  logic       NextCA;
  logic       NextREUA;
  logic       XferEnd;
  logic       VerifyErr;
  logic       Busy;

  // Sequencer side
  modport master (
    input  ExecuteIn, FF00DecodeIn, XferTypeIn, Length1, FF00Wr, BA, CDIn, RDIn,
    output DMAReq, CRnW, RAMWE, CDOut, RDOut, NextCA, NextREUA, XferEnd, VerifyErr, Busy
  );

  // Register file / bus side
  modport slave (
    output ExecuteIn, FF00DecodeIn, XferTypeIn, Length1, FF00Wr, BA, CDIn, RDIn,
    input  DMAReq, CRnW, RAMWE, CDOut, RDOut, NextCA, NextREUA, XferEnd, VerifyErr, Busy
  );
endinterface

// File: rtl/reu_xfer_data.sv
// rtl/reu_xfer_data.sv - swap latches, verify comparator and C64/REU data output muxes
module reu_xfer_data
  import reu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       latch_en,   // swap read cycle with the bus granted
  input  logic       stash_en,   // stash byte cycle with the bus granted
  input  logic       fetch_en,   // fetch byte cycle with the bus granted
  input  logic       swapwr_en,  // swap write-back cycle with the bus granted
  input  logic [7:0] cd_in,
  input  logic [7:0] rd_in,
  output logic [7:0] cd_out,
  output logic [7:0] rd_out,
  output logic       mismatch
);

  logic [7:0] swap_c_q, swap_c_d;
  logic [7:0] swap_r_q, swap_r_d;

  // Capture both sides of a swap on its read cycle, hold otherwise (incl. BA stalls)
  always_comb begin
    swap_c_d = swap_c_q;
    swap_r_d = swap_r_q;
    if (latch_en) begin
      swap_c_d = cd_in;
      swap_r_d = rd_in;
    end
  end

  // Latch registers update on the PHI2 falling edge
  always_ff @(negedge clk) begin
    if (rst) begin
      swap_c_q <= 8'h00;
      swap_r_q <= 8'h00;
    end else begin
      swap_c_q <= swap_c_d;
      swap_r_q <= swap_r_d;
    end
  end

  // Data toward the C64 bus and REU RAM; idle value is zero so reset/idle outputs are clean
  always_comb begin
    cd_out = 8'h00;
    rd_out = 8'h00;
    if (stash_en) begin
      rd_out = cd_in;
    end
    if (fetch_en) begin
      cd_out = rd_in;
    end
    if (swapwr_en) begin
      rd_out = swap_c_q;
      cd_out = swap_r_q;
    end
  end

  assign mismatch = (cd_in != rd_in);

endmodule

// File: rtl/reu_xfer_seq.sv
// rtl/reu_xfer_seq.sv - REU DMA transfer sequencer FSM; REU_XFER_FF00_EN enables the ARM/$FF00 trigger
module reu_xfer_seq
  import reu_pkg::*;
(
  input logic            PHI2,
  input logic            Reset,
  reu_xfer_seq_if.master bus
);

  logic [2:0] state_q, state_d;
  logic       err_q, err_d;
  xfer_type_e xtype;
  logic       ff00_decode;
  logic       ff00_wr;
  logic       xfer_act;
  logic       swapwr_act;
  logic       mismatch;
  strobe_t    stb;

  assign xtype      = xfer_type_e'(bus.XferTypeIn);
  assign xfer_act   = (state_q == ST_XFER) && bus.BA;
  assign swapwr_act = (state_q == ST_SWAPWR) && bus.BA;

`ifdef REU_XFER_FF00_EN
  assign ff00_decode = bus.FF00DecodeIn;
  assign ff00_wr     = bus.FF00Wr;
`else
  logic unused_ff00;
  assign ff00_decode = 1'b0;
  assign ff00_wr     = 1'b0;
  assign unused_ff00 = bus.FF00DecodeIn ^ bus.FF00Wr;
`endif

  reu_xfer_data u_data (
    .clk       (PHI2),
    .rst       (Reset),
    .latch_en  (xfer_act && (xtype == XT_SWAP)),
    .stash_en  (xfer_act && (xtype == XT_STASH)),
    .fetch_en  (xfer_act && (xtype == XT_FETCH)),
    .swapwr_en (swapwr_act),
    .cd_in     (bus.CDIn),
    .rd_in     (bus.RDIn),
    .cd_out    (bus.CDOut),
    .rd_out    (bus.RDOut),
    .mismatch  (mismatch)
  );

  // Next-state and error-flag logic; BA=0 in XFER/SWAPWR simply holds everything
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.ExecuteIn) begin
          state_d = ff00_decode ? ST_ARM : ST_WAITBA;
        end
      end
      ST_ARM: begin
        if (!bus.ExecuteIn) begin
          state_d = ST_IDLE;
        end else if (ff00_wr) begin
          state_d = ST_WAITBA;
        end
      end
      ST_WAITBA: begin
        if (bus.BA) begin
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (bus.BA) begin
          case (xtype)
            XT_SWAP: state_d = ST_SWAPWR;
            XT_VERIFY: begin
              if (mismatch) begin
                err_d   = 1'b1;
                state_d = ST_DONE;
              end else if (bus.Length1) begin
                state_d = ST_DONE;
              end
            end
            default: begin
              if (bus.Length1) begin
                state_d = ST_DONE;
              end
            end
          endcase
        end
      end
      ST_SWAPWR: begin
        if (bus.BA) begin
          state_d = bus.Length1 ? ST_DONE : ST_XFER;
        end
      end
      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and error flag advance on the PHI2 falling edge
  always_ff @(negedge PHI2) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Byte-cycle strobes; nothing fires while the VIC holds the bus
  always_comb begin
    stb = '0;
    if (xfer_act) begin
      case (xtype)
        XT_STASH: begin
          stb.ram_we    = 1'b1;
          stb.next_ca   = 1'b1;
          stb.next_reua = 1'b1;
        end
        XT_FETCH: begin
          stb.c_wr      = 1'b1;
          stb.next_ca   = 1'b1;
          stb.next_reua = 1'b1;
        end
        XT_VERIFY: begin
          stb.next_ca   = 1'b1;
          stb.next_reua = 1'b1;
        end
        default: stb = '0;
      endcase
    end
    if (swapwr_act) begin
      stb.ram_we    = 1'b1;
      stb.c_wr      = 1'b1;
      stb.next_ca   = 1'b1;
      stb.next_reua = 1'b1;
    end
  end

  assign bus.NextCA    = stb.next_ca;
  assign bus.NextREUA  = stb.next_reua;
  assign bus.RAMWE     = stb.ram_we;
  assign bus.CRnW      = ~stb.c_wr;
  assign bus.DMAReq    = (state_q == ST_WAITBA) || (state_q == ST_XFER) || (state_q == ST_SWAPWR);
  assign bus.Busy      = (state_q != ST_IDLE);
  assign bus.XferEnd   = (state_q == ST_DONE) && !err_q;
  assign bus.VerifyErr = (state_q == ST_DONE) && err_q;

endmodule
